fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 102 ++++++++++
 tb/tb_fetch_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: fetch PC register feeding a DEPTH-entry {pc, instr} queue
// whose registered head drives the decode-side outputs.
module fetch_unit #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        stall_d,
   output logic        valid_d,
   output logic [31:0] instr_d,
   output logic [31:0] pc_d,
   output logic [31:0] pc_plus4_d
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [31:0]   fifo_pc_q    [DEPTH];
   logic [31:0]   fifo_pc_d    [DEPTH];
   logic [31:0]   fifo_instr_q [DEPTH];
   logic [31:0]   fifo_instr_d [DEPTH];

   logic head_valid;
   logic pop;
   logic push;

   assign imem_addr  = fetch_pc_q;
   assign head_valid = (count_q != '0);
   assign pop        = head_valid & ~stall_d & ~redirect_valid;
   // A full queue still accepts a fetch when the head leaves in the same cycle.
   assign push       = ~redirect_valid & ((count_q < DEPTH_C) | pop);

   always_comb begin
      fetch_pc_d   = fetch_pc_q;
      count_d      = count_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      fifo_pc_d    = fifo_pc_q;
      fifo_instr_d = fifo_instr_q;
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
      end else begin
         if (push) begin
            fifo_pc_d[wr_ptr_q]    = fetch_pc_q;
            fifo_instr_d[wr_ptr_q] = imem_rdata;
            wr_ptr_d               = wr_ptr_q + PW'(1);
            fetch_pc_d             = fetch_pc_q + 32'd4;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         fetch_pc_q <= RESET_PC;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
      end
   end

   // Queue storage needs no reset: entries are only visible while count is non-zero.
   always_ff @(posedge clk) begin
      fifo_pc_q    <= fifo_pc_d;
      fifo_instr_q <= fifo_instr_d;
   end

   always_comb begin
      valid_d    = head_valid;
      instr_d    = NOP;
      pc_d       = '0;
      pc_plus4_d = '0;
      if (head_valid) begin
         instr_d    = fifo_instr_q[rd_ptr_q];
         pc_d       = fifo_pc_q[rd_ptr_q];
         pc_plus4_d = fifo_pc_q[rd_ptr_q] + 32'd4;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// stall/redirect/reset traffic checked against a queue-based reference model.
module tb_fetch_unit;

   localparam int unsigned DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        stall_d;
   logic        valid_d;
   logic [31:0] instr_d;
   logic [31:0] pc_d;
   logic [31:0] pc_plus4_d;

   int checks;
   int errors;

   // Reference model: fetch PC plus a queue of fetched addresses.
   logic [31:0] m_pc;
   logic [31:0] mq[$];

   fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .stall_d        (stall_d),
      .valid_d        (valid_d),
      .instr_d        (instr_d),
      .pc_d           (pc_d),
      .pc_plus4_d     (pc_plus4_d)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0:   mem_word = 32'h0000_02B3;
         32'h4:   mem_word = 32'h0000_0333;
         32'h8:   mem_word = 32'h0062_8863;
         default: mem_word = {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
      endcase
   endfunction

   always_comb imem_rdata = mem_word(imem_addr);

   // Advance the model by one clock using the inputs currently applied, then clock the DUT.
   task automatic tick();
      bit pop_m, push_m;
      if (!rst) begin
         m_pc = RESET_PC;
         mq.delete();
      end else if (redirect_valid) begin
         m_pc = {redirect_pc[31:2], 2'b00};
         mq.delete();
      end else begin
         pop_m  = (mq.size() != 0) && !stall_d;
         push_m = (mq.size() < DEPTH) || pop_m;
         if (pop_m) void'(mq.pop_front());
         if (push_m) begin
            mq.push_back(m_pc);
            m_pc = m_pc + 32'd4;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; stall_d = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40; stall_d = 1'b1;
      tick();
      tick();
      checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", valid_d); end
      checks++; if (instr_d !== NOP) begin errors++; $display("FAIL reset_instr got %h want %h", instr_d, NOP); end
      checks++; if (pc_d !== 32'h0 || pc_plus4_d !== 32'h0) begin errors++; $display("FAIL reset_pc got %h/%h want 0/0", pc_d, pc_plus4_d); end
      checks++; if (imem_addr !== RESET_PC) begin errors++; $display("FAIL reset_imem_addr got %h want %h", imem_addr, RESET_PC); end
   endtask

   task automatic test_basic();
      logic [31:0] exp_i[3];
      exp_i[0] = 32'h0000_02B3; exp_i[1] = 32'h0000_0333; exp_i[2] = 32'h0062_8863;
      rst = 1'b1; redirect_valid = 1'b0; stall_d = 1'b0;
      checks++; if (valid_d !== 1'b0 || imem_addr !== RESET_PC) begin errors++; $display("FAIL basic_first_cycle got valid=%0b addr=%h want 0/%h", valid_d, imem_addr, RESET_PC); end
      for (int unsigned i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (valid_d !== 1'b1 || instr_d !== exp_i[i] || pc_d !== 32'(4*i) || pc_plus4_d !== 32'(4*i+4)) begin
            errors++;
            $display("FAIL basic_seq%0d got v=%0b i=%h pc=%h p4=%h want 1 %h %h %h", i, valid_d, instr_d, pc_d, pc_plus4_d, exp_i[i], 32'(4*i), 32'(4*i+4));
         end
      end
   endtask

   task automatic test_stall();
      do_reset();
      rst = 1'b1; stall_d = 1'b1;
      for (int unsigned i = 0; i < 6; i++) tick();
      checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL stall_addr got %h want 00000010", imem_addr); end
      checks++; if (valid_d !== 1'b1 || instr_d !== 32'h0000_02B3) begin errors++; $display("FAIL stall_head got v=%0b i=%h want 1 000002b3", valid_d, instr_d); end
      stall_d = 1'b0;
      for (int unsigned i = 0; i < 8; i++) begin
         checks++;
         if (valid_d !== 1'b1 || pc_d !== 32'(4*i)) begin
            errors++;
            $display("FAIL stall_drain%0d got v=%0b pc=%h want 1 %h", i, valid_d, pc_d, 32'(4*i));
         end
         tick();
      end
   endtask

   task automatic test_redirect();
      // Queue pre-filled starting at 0x8 so the redirect discards live entries.
      redirect_valid = 1'b1; redirect_pc = 32'h8; tick();
      redirect_valid = 1'b0; stall_d = 1'b1;
      for (int unsigned i = 0; i < 3; i++) tick();
      redirect_valid = 1'b1; redirect_pc = 32'h14; stall_d = 1'b0;
      tick();
      redirect_valid = 1'b0;
      checks++; if (valid_d !== 1'b0 || imem_addr !== 32'h14) begin errors++; $display("FAIL redir_n1 got v=%0b addr=%h want 0 00000014", valid_d, imem_addr); end
      tick();
      checks++; if (valid_d !== 1'b1 || pc_d !== 32'h14 || pc_plus4_d !== 32'h18) begin errors++; $display("FAIL redir_n2 got v=%0b pc=%h p4=%h want 1 14 18", valid_d, pc_d, pc_plus4_d); end
      checks++; if (instr_d !== mem_word(32'h14)) begin errors++; $display("FAIL redir_instr got %h want %h", instr_d, mem_word(32'h14)); end
   endtask

   task automatic test_redirect_stall_full();
      do_reset();
      rst = 1'b1; stall_d = 1'b1;
      for (int unsigned i = 0; i < 5; i++) tick();
      redirect_valid = 1'b1; redirect_pc = 32'h2B;
      tick();
      redirect_valid = 1'b0;
      checks++; if (valid_d !== 1'b0 || imem_addr !== 32'h28) begin errors++; $display("FAIL redir_full got v=%0b addr=%h want 0 00000028", valid_d, imem_addr); end
      tick();
      checks++; if (valid_d !== 1'b1 || pc_d !== 32'h28) begin errors++; $display("FAIL redir_full_head got v=%0b pc=%h want 1 00000028", valid_d, pc_d); end
      stall_d = 1'b0;
   endtask

   task automatic test_wrap();
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; stall_d = 1'b0;
      tick();
      redirect_valid = 1'b0;
      tick();
      checks++; if (pc_d !== 32'hFFFF_FFFC || pc_plus4_d !== 32'h0) begin errors++; $display("FAIL wrap_first got pc=%h p4=%h want fffffffc 00000000", pc_d, pc_plus4_d); end
      tick();
      checks++; if (pc_d !== 32'h0 || instr_d !== 32'h0000_02B3) begin errors++; $display("FAIL wrap_second got pc=%h i=%h want 00000000 000002b3", pc_d, instr_d); end
   endtask

   task automatic test_reset_mid();
      stall_d = 1'b1;
      for (int unsigned i = 0; i < 5; i++) tick();
      checks++; if (imem_addr !== 32'h0000_0010) begin errors++; $display("FAIL mid_prefill_addr got %h want 00000010", imem_addr); end
      rst = 1'b0;
      tick();
      rst = 1'b1;
      checks++; if (valid_d !== 1'b0 || imem_addr !== RESET_PC || instr_d !== NOP) begin errors++; $display("FAIL reset_mid got v=%0b addr=%h i=%h want 0 %h %h", valid_d, imem_addr, instr_d, RESET_PC, NOP); end
      stall_d = 1'b0;
   endtask

   task automatic test_random();
      logic        e_valid;
      logic [31:0] e_pc, e_instr, e_p4;
      for (int unsigned cyc = 0; cyc < 2000; cyc++) begin
         rst            = ($urandom_range(99) >= 2);
         stall_d        = ($urandom_range(1) == 1);
         redirect_valid = ($urandom_range(99) < 6);
         redirect_pc    = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
         e_valid = (mq.size() != 0);
         e_pc    = e_valid ? mq[0] : 32'h0;
         e_p4    = e_valid ? mq[0] + 32'd4 : 32'h0;
         e_instr = e_valid ? mem_word(mq[0]) : NOP;
         checks++;
         if (valid_d !== e_valid || pc_d !== e_pc || pc_plus4_d !== e_p4 || instr_d !== e_instr || imem_addr !== m_pc) begin
            errors++;
            $display("FAIL random_cyc%0d got v=%0b pc=%h p4=%h i=%h a=%h want v=%0b pc=%h p4=%h i=%h a=%h",
                     cyc, valid_d, pc_d, pc_plus4_d, instr_d, imem_addr, e_valid, e_pc, e_p4, e_instr, m_pc);
         end
         tick();
      end
   endtask

   initial begin
      checks = 0; errors = 0;
      m_pc = RESET_PC;
      rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; stall_d = 1'b0;
      test_reset();
      test_basic();
      test_stall();
      test_redirect();
      test_redirect_stall_full();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
